// File: rtl/dac7611_serial_rx.sv
// Receive-side model of the DAC7611 3-wire serial interface: synchronizes CLK/SDI/LD/CLR,
// shifts 12-bit words MSB-first and latches them on LD. Optional DAC_RX_COMPARE_EN adds code compare.
module dac7611_serial_rx #(
    parameter int                   DATA_BITS     = 12,
    parameter int                   SYNC_STAGES   = 2,
    parameter logic [DATA_BITS-1:0] CLR_VALUE     = 12'h000,
    parameter logic [DATA_BITS-1:0] EXPECTED_CODE = 12'h555
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           dac_signals_in,
    output logic [DATA_BITS-1:0] dac_code,
    output logic                 code_valid,
    output logic                 frame_error,
    output logic [3:0]           bit_count,
    output logic [15:0]          load_count,
    output logic [7:0]           err_count
`ifdef DAC_RX_COMPARE_EN
    ,
    output logic                 code_match,
    output logic [7:0]           mismatch_count
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, OVERRUN} state_t;

    state_t                          state_q, state_d;
    logic [SYNC_STAGES-1:0][3:0]     sync_q;
    logic                            clk_hist_q, ld_hist_q;
    logic [DATA_BITS-1:0]            shift_q, shift_d;
    logic [3:0]                      sync_s, cnt_inc, cnt_after_clk, bit_count_d;
    logic                            clk_rise, ld_fall, clr_low, do_load, load_err;

    // Bus idles with CLK, LD and CLR high, so the chains reset to all ones to avoid false edges.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q     <= '1;
            clk_hist_q <= 1'b1;
            ld_hist_q  <= 1'b1;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], dac_signals_in};
            clk_hist_q <= sync_s[3];
            ld_hist_q  <= sync_s[1];
        end
    end

    assign sync_s   = sync_q[SYNC_STAGES-1];
    assign clk_rise = sync_s[3] & ~clk_hist_q;
    assign ld_fall  = ~sync_s[1] & ld_hist_q;
    assign clr_low  = ~sync_s[0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clr_low || ld_fall) begin
            state_d = IDLE;
        end else if (clk_rise) begin
            case (state_q)
                IDLE:    state_d = SHIFT;
                SHIFT:   state_d = (cnt_inc > 4'(DATA_BITS)) ? OVERRUN : SHIFT;
                default: state_d = OVERRUN;
            endcase
        end
    end

    // A CLK rise coinciding with LD fall is shifted first, so the load and its error check see the new bit.
    always_comb begin
        cnt_inc       = (bit_count == 4'hF) ? 4'hF : bit_count + 4'd1;
        cnt_after_clk = clk_rise ? cnt_inc : bit_count;
        shift_d       = clk_rise ? {shift_q[DATA_BITS-2:0], sync_s[2]} : shift_q;
        do_load       = ld_fall & ~clr_low;
        load_err      = do_load && (cnt_after_clk != 4'(DATA_BITS));
        bit_count_d   = (clr_low || ld_fall) ? 4'd0 : cnt_after_clk;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_q     <= '0;
            dac_code    <= '0;
            code_valid  <= 1'b0;
            frame_error <= 1'b0;
            bit_count   <= 4'd0;
            load_count  <= 16'd0;
            err_count   <= 8'd0;
        end else begin
            shift_q     <= shift_d;
            code_valid  <= do_load;
            frame_error <= load_err;
            bit_count   <= bit_count_d;
            if (clr_low)      dac_code <= CLR_VALUE;
            else if (do_load) dac_code <= shift_d;
            if (do_load)      load_count <= load_count + 16'd1;
            if (load_err && err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

`ifdef DAC_RX_COMPARE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            code_match     <= 1'b0;
            mismatch_count <= 8'd0;
        end else begin
            if (clr_low)      code_match <= 1'b0;
            else if (do_load) code_match <= (shift_d == EXPECTED_CODE);
            if (do_load && shift_d != EXPECTED_CODE && mismatch_count != 8'hFF)
                mismatch_count <= mismatch_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_dac7611_serial_rx.sv
// Bench for dac7611_serial_rx: directed frames drive the serial pins, a monitor
// pops expected loads from a queue whenever code_valid pulses.
module tb_dac7611_serial_rx;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        dac_clk = 1'b1, sdi = 1'b0, ld_n = 1'b1, clr_n = 1'b1;
    logic [3:0]  dac_signals_in;
    logic [11:0] dac_code;
    logic        code_valid, frame_error;
    logic [3:0]  bit_count;
    logic [15:0] load_count;
    logic [7:0]  err_count;
`ifdef DAC_RX_COMPARE_EN
    logic        code_match;
    logic [7:0]  mismatch_count;
`endif

    int n_vec = 0;
    int n_err = 0;

    // Expected load: {code[11:0], frame_error, load_count[15:0], err_count[7:0]}
    logic [36:0] exp_q[$];

    assign dac_signals_in = {dac_clk, sdi, ld_n, clr_n};

    always #5 clk = ~clk;

    dac7611_serial_rx dut (
        .clk(clk), .reset(reset), .dac_signals_in(dac_signals_in),
        .dac_code(dac_code), .code_valid(code_valid), .frame_error(frame_error),
        .bit_count(bit_count), .load_count(load_count), .err_count(err_count)
`ifdef DAC_RX_COMPARE_EN
        , .code_match(code_match), .mismatch_count(mismatch_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every code_valid pulse must match the oldest expected load.
    always @(negedge clk) begin
        if (!reset && code_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_code_valid", 32'd1, 32'd0);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                check("load_code",  {20'd0, dac_code},    {20'd0, e[36:25]});
                check("load_ferr",  {31'd0, frame_error}, {31'd0, e[24]});
                check("load_count", {16'd0, load_count},  {16'd0, e[23:8]});
                check("err_count",  {24'd0, err_count},   {24'd0, e[7:0]});
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk); dac_clk = 1'b0; sdi = b;
        @(negedge clk);
        @(negedge clk); dac_clk = 1'b1;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [16:0] val, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) send_bit(val[i]);
        idle(3);
    endtask

    task automatic load(input logic [11:0] code, input logic ferr, input logic [15:0] lc,
                        input logic [7:0] ec, input logic [3:0] cnt_before);
        check("bit_count_before_ld", {28'd0, bit_count}, {28'd0, cnt_before});
        exp_q.push_back({code, ferr, lc, ec});
        @(negedge clk); ld_n = 1'b0;
        idle(2);
        ld_n = 1'b1;
        idle(6);
        check("load_seen", exp_q.size(), 32'd0);
        exp_q.delete();
        check("bit_count_after_ld", {28'd0, bit_count}, 32'd0);
    endtask

    initial begin
        idle(3);
        check("rst_dac_code",   {20'd0, dac_code},   32'd0);
        check("rst_code_valid", {31'd0, code_valid}, 32'd0);
        check("rst_bit_count",  {28'd0, bit_count},  32'd0);
        check("rst_load_count", {16'd0, load_count}, 32'd0);
        check("rst_err_count",  {24'd0, err_count},  32'd0);
        reset = 1'b0;
        idle(3);

        send_word(17'h00555, 12);
        load(12'h555, 1'b0, 16'd1, 8'd0, 4'd12);

        // 10 bits 0x3A5 on top of 0x555: retains low "01" from the previous word.
        send_word(17'h003A5, 10);
        load(12'h7A5, 1'b1, 16'd2, 8'd1, 4'd10);

        send_word(17'h02ABC, 14);
        load(12'hABC, 1'b1, 16'd3, 8'd2, 4'd14);

        send_word(17'h1ABCD, 17);
        load(12'hBCD, 1'b1, 16'd4, 8'd3, 4'd15);

        send_word(17'h00555, 12);
        load(12'h555, 1'b0, 16'd5, 8'd3, 4'd12);

        @(negedge clk); clr_n = 1'b0;
        @(negedge clk); clr_n = 1'b1;
        idle(5);
        check("clr_dac_code",   {20'd0, dac_code},   32'd0);
        check("clr_load_count", {16'd0, load_count}, 32'd5);
        check("clr_bit_count",  {28'd0, bit_count},  32'd0);

        send_word(17'h000F0, 12);
        load(12'h0F0, 1'b0, 16'd6, 8'd3, 4'd12);

        // Reset mid-frame discards the partial word.
        for (int i = 0; i < 6; i++) send_bit(1'b1);
        @(negedge clk); reset = 1'b1;
        idle(2);
        check("mid_rst_dac_code",   {20'd0, dac_code},   32'd0);
        check("mid_rst_load_count", {16'd0, load_count}, 32'd0);
        check("mid_rst_bit_count",  {28'd0, bit_count},  32'd0);
        reset = 1'b0;
        idle(3);
        send_word(17'h00123, 12);
        load(12'h123, 1'b0, 16'd1, 8'd0, 4'd12);

`ifdef DAC_RX_COMPARE_EN
        check("cmp_after_123", {31'd0, code_match}, 32'd0);
        send_word(17'h00555, 12);
        load(12'h555, 1'b0, 16'd2, 8'd0, 4'd12);
        check("cmp_match_555", {31'd0, code_match},     32'd1);
        check("cmp_mismatch1", {24'd0, mismatch_count}, 32'd1);
        send_word(17'h00554, 12);
        load(12'h554, 1'b0, 16'd3, 8'd0, 4'd12);
        check("cmp_match_554", {31'd0, code_match},     32'd0);
        check("cmp_mismatch2", {24'd0, mismatch_count}, 32'd2);
`endif

        idle(4);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dac7611_serial_rx.md
Name: dac7611_serial_rx

Overview:
- Receive-side model of the DAC7611 3-wire serial interface.
- Samples CLK/SDI/LD/CLR, as driven by the DAC driver or by the board's DAC nets, using the system clock.
- Shifts in 12-bit words MSB-first, latches them on the LD load pulse and honours CLR.
- Used for loopback and PCB bring-up checks of the DAC drive path; reports the received code, per-load status and running counters.

Parameters:
- DATA_BITS, 12, bits per frame; D11 (MSB) is sent first.
- SYNC_STAGES, 2, synchronizer flops per input, minimum 2.
- CLR_VALUE, 12'h000, value loaded into dac_code while CLR is low.
- EXPECTED_CODE, 12'h555, reference word used only by the optional compare feature.

Ports:
- clk  in  1  system clock (5 MHz in the bring-up build).
- reset  in  1  asynchronous, active-high; clears all state.
- dac_signals_in  in  4  [3]=CLK, [2]=SDI, [1]=LD (active low), [0]=CLR (active low).
- dac_code  out  12  currently latched DAC register value.
- code_valid  out  1  one-cycle pulse when a load completes.
- frame_error  out  1  one-cycle pulse with code_valid when the bit count at load is not DATA_BITS.
- bit_count  out  4  CLK rising edges seen since the last load or clear; saturates at 15.
- load_count  out  16  completed loads (good or errored); wraps at 16'hFFFF to 0.
- err_count  out  8  errored loads; saturates at 8'hFF.
- code_match  out  1  present only with DAC_RX_COMPARE_EN.
- mismatch_count  out  8  present only with DAC_RX_COMPARE_EN.

Behaviour:
- Reset values:
  - Synchronizer chains reset to 4'b1111 (bus idle: CLK high, LD high, CLR high).
  - Edge-history registers reset to the same idle values.
  - Shift register = 0, dac_code = 0, code_valid = 0, frame_error = 0.
  - bit_count = 0, load_count = 0, err_count = 0.
  - State = IDLE.
- Input path:
  - Each input passes through SYNC_STAGES flops, then a 1-flop history register.
  - Edge detects are formed from the synchronized value against its history.
  - Input-to-action latency is SYNC_STAGES+1 clk edges.
  - Minimum resolvable pulse is 1 clk cycle high or low.
- CLK rise (sync=1, hist=0):
  - shift_reg <= {shift_reg[DATA_BITS-2:0], SDI_sync}.
  - bit_count increments, saturating at 15.
- States:
  - IDLE: bit_count == 0. A CLK rise moves to SHIFT.
  - SHIFT: 1 <= bit_count <= DATA_BITS.
  - OVERRUN: bit_count > DATA_BITS. The shift register keeps shifting, so the last DATA_BITS bits are retained.
  - From any state, an LD fall or a CLR low returns to IDLE.
- LD fall (sync=0, hist=1):
  - dac_code <= shift_reg; code_valid = 1 for exactly one cycle.
  - frame_error = 1 in the same cycle if bit_count != DATA_BITS; err_count then increments.
  - load_count increments.
  - bit_count <= 0.
  - LD held low produces no further loads; CLK edges while LD is low still shift.
- CLR low (level, synchronized):
  - dac_code <= CLR_VALUE every cycle CLR is low.
  - bit_count <= 0; state returns to IDLE.
  - No code_valid, no counter change.
  - The shift register is unaffected.
- Simultaneous events, same cycle:
  - CLK rise + LD fall: the shift happens first and the loaded value includes the new bit. The count used for the error check is the incremented count.
  - CLR low + LD fall: CLR wins; no load pulse, no load_count change.
  - CLR low + CLK rise: the shift register shifts, but bit_count is forced to 0.
- Reset asserted mid-frame: all state returns to reset values immediately. A partial frame is discarded.

Optional Feature:
- Macro: DAC_RX_COMPARE_EN.
- Defined:
  - On every code_valid, code_match is registered as (shift value loaded == EXPECTED_CODE) and held until the next load or CLR.
  - CLR low forces code_match = 0.
  - mismatch_count increments, saturating at 8'hFF, on each load whose value != EXPECTED_CODE.
  - Both reset to 0.
- Undefined: code_match and mismatch_count ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Send 12 CLK pulses (2 cycles low, 2 high) carrying bits 0,1,0,1,... MSB-first, then LD low for 2 cycles.
  - Expect dac_code = 12'h555.
  - Expect a single code_valid pulse SYNC_STAGES+1 cycles after LD falls, with frame_error = 0.
  - Expect load_count = 1, bit_count back at 0.
- Send a 10-bit frame, then LD.
  - Expect code_valid with frame_error = 1 and err_count = 1.
  - Expect dac_code = the last 12 shift-register bits.
- Send a 14-bit frame ending ...0xABC, then LD.
  - Expect dac_code = 12'hABC, frame_error = 1, bit_count saturating behaviour correct.
- Load 12'h555, then pulse CLR low for 1 cycle.
  - Expect dac_code = CLR_VALUE (0).
  - Expect no code_valid and load_count unchanged.
  - Expect the next full frame of 12'h0F0 to load correctly.
- Assert reset after 6 bits of a frame, then send a full 12'h123 frame and LD.
  - Expect dac_code = 12'h123, frame_error = 0, load_count = 1.
- With DAC_RX_COMPARE_EN defined, load 12'h555 then 12'h554.
  - Expect code_match = 1, then 0.
  - Expect mismatch_count = 1.
